inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit_pkg.sv | 25 ++
 rtl/inst_fetch_unit_if.sv | 41 ++++
 rtl/inst_fetch_unit_next_pc_logic.sv | 45 ++++
 rtl/inst_fetch_unit.sv | 95 +++++++++
 tb/tb_inst_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared state encoding, opcode constants and reset default for the fetch unit.
// Optional register-indirect jump support is enabled with INST_FETCH_JR_EN.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instruction addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment (imem, datapath, decoder).
// Jump_Reg/Reg_Target exist only when INST_FETCH_JR_EN is defined.
interface inst_fetch_unit_if;
    logic        Imem_Req_Valid;
    logic        Imem_Req_Ready;
    logic [31:0] Imem_Addr;
    logic        Imem_Rsp_Valid;
    logic [31:0] Imem_Rsp_Data;
    logic [31:0] Inst;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] PC_Out;
    logic [31:0] PC_Plus4;
    logic        Branch;
    logic        Branch_Not_Equal;
    logic        Jump;
    logic        Zero;
`ifdef INST_FETCH_JR_EN
    logic        Jump_Reg;
    logic [31:0] Reg_Target;
`endif

    modport master (
        output Imem_Req_Valid, Imem_Addr, Inst, Inst_Valid, PC_Out, PC_Plus4,
        input  Imem_Req_Ready, Imem_Rsp_Valid, Imem_Rsp_Data, Inst_Ready,
        input  Branch, Branch_Not_Equal, Jump, Zero
`ifdef INST_FETCH_JR_EN
        , input Jump_Reg, Reg_Target
`endif
    );

    modport slave (
        input  Imem_Req_Valid, Imem_Addr, Inst, Inst_Valid, PC_Out, PC_Plus4,
        output Imem_Req_Ready, Imem_Rsp_Valid, Imem_Rsp_Data, Inst_Ready,
        output Branch, Branch_Not_Equal, Jump, Zero
`ifdef INST_FETCH_JR_EN
        , output Jump_Reg, Reg_Target
`endif
    );

endinterface

// File: rtl/inst_fetch_unit_next_pc_logic.sv
// Combinational next-PC select: [Jump_Reg >] Jump > taken branch > PC+4.
// Jump_Reg is present only when INST_FETCH_JR_EN is defined.
module next_pc_logic
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] inst_i,
    input  logic        branch_i,
    input  logic        bne_i,
    input  logic        jump_i,
    input  logic        zero_i,
`ifdef INST_FETCH_JR_EN
    input  logic        jump_reg_i,
    input  logic [31:0] reg_target_i,
`endif
    output logic [31:0] next_pc_o
);

    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        branch_taken;
    logic        unused_opcode;

    // Opcode is decoded upstream; only the immediate fields matter here.
    assign unused_opcode = ^inst_i[31:26];

    assign jump_target   = {pc_plus4_i[31:28], inst_i[25:0], 2'b00};
    assign branch_target = pc_plus4_i + {{14{inst_i[15]}}, inst_i[15:0], 2'b00};
    assign branch_taken  = (branch_i && zero_i) || (bne_i && !zero_i);

    always_comb begin
        next_pc_o = pc_plus4_i;
        if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_taken) begin
            next_pc_o = branch_target;
        end
`ifdef INST_FETCH_JR_EN
        if (jump_reg_i) begin
            next_pc_o = align_word(reg_target_i);
        end
`endif
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC register, imem request/response FSM, held instruction.
// Define INST_FETCH_JR_EN to add register-indirect jumps (Jump_Reg/Reg_Target).
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    inst_fetch_unit_if.master  bus
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] next_pc;
    logic              req_valid;

    // Request is suppressed while Reset is held so the reset-cycle value reads 0.
    assign req_valid = (state_q == REQ) && !Reset;
    assign pc_plus4  = pc_out_q + 32'd4;

    next_pc_logic u_next_pc (
        .pc_plus4_i   (pc_plus4),
        .inst_i       (inst_q),
        .branch_i     (bus.Branch),
        .bne_i        (bus.Branch_Not_Equal),
        .jump_i       (bus.Jump),
        .zero_i       (bus.Zero),
`ifdef INST_FETCH_JR_EN
        .jump_reg_i   (bus.Jump_Reg),
        .reg_target_i (bus.Reg_Target),
`endif
        .next_pc_o    (next_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_out_d     = pc_out_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        case (state_q)
            REQ: begin
                if (req_valid && bus.Imem_Req_Ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.Imem_Rsp_Valid) begin
                    inst_d       = bus.Imem_Rsp_Data;
                    inst_valid_d = 1'b1;
                    pc_out_d     = pc_q;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (bus.Inst_Ready) begin
                    pc_d         = align_word(next_pc);
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= REQ;
            pc_q         <= RESET_PC;
            pc_out_q     <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_out_q     <= pc_out_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign bus.Imem_Req_Valid = req_valid;
    assign bus.Imem_Addr      = pc_q;
    assign bus.Inst           = inst_q;
    assign bus.Inst_Valid     = inst_valid_q;
    assign bus.PC_Out         = pc_out_q;
    assign bus.PC_Plus4       = pc_plus4;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus a randomized
// instruction stream checked against an arithmetic next-PC reference model.
module tb_inst_fetch_unit;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    inst_fetch_unit_if ifc ();

    inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (ifc)
    );

`ifdef INST_FETCH_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] mpc;

    always @(posedge Clk) cyc = cyc + 1;

    // Reference: next PC from the instruction-set rules, in 64-bit arithmetic mod 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] word,
                                             input bit b, input bit bn, input bit j,
                                             input bit z, input bit jr, input logic [31:0] rt);
        longint p4;
        longint off;
        int     imm;
        p4 = (longint'(pc) + 4) % 64'h1_0000_0000;
        if (JR_EN && jr) return rt - (rt % 4);
        if (j) return logic'(32'(p4 / 32'h1000_0000 * 32'h1000_0000)) | ((word % 32'h0400_0000) * 4);
        if ((b && z) || (bn && !z)) begin
            imm = $signed(word[15:0]);
            off = longint'(imm) * 4;
            return 32'(((p4 + off) % 64'h1_0000_0000 + 64'h1_0000_0000) % 64'h1_0000_0000);
        end
        return 32'(p4);
    endfunction

    task automatic idle_inputs();
        ifc.Imem_Req_Ready   = 1'b0;
        ifc.Imem_Rsp_Valid   = 1'b0;
        ifc.Imem_Rsp_Data    = 32'h0;
        ifc.Inst_Ready       = 1'b0;
        ifc.Branch           = 1'b0;
        ifc.Branch_Not_Equal = 1'b0;
        ifc.Jump             = 1'b0;
        ifc.Zero             = 1'b0;
`ifdef INST_FETCH_JR_EN
        ifc.Jump_Reg         = 1'b0;
        ifc.Reg_Target       = 32'h0;
`endif
    endtask

    task automatic apply_reset();
        idle_inputs();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        mpc = 32'h0;
    endtask

    // One full instruction: request (rs stall cycles), response after rl cycles,
    // hold for hs cycles, retire with the given decoder inputs. Entered/left at a negedge in REQ.
    task automatic fetch(input logic [31:0] word, input int rs, input int rl, input int hs,
                         input bit b, input bit bn, input bit j, input bit z,
                         input bit jr, input logic [31:0] rt, input string tag);
        logic [31:0] exp_next;
        checks++;
        if (ifc.Imem_Req_Valid !== 1'b1 || ifc.Imem_Addr !== mpc) begin
            failures++;
            $display("FAIL %s req: valid=%b addr=%h, want valid=1 addr=%h", tag, ifc.Imem_Req_Valid, ifc.Imem_Addr, mpc);
        end
        repeat (rs) begin
            ifc.Imem_Rsp_Valid = 1'($urandom);
            ifc.Imem_Rsp_Data  = $urandom;
            @(negedge Clk);
            checks++;
            if (ifc.Imem_Req_Valid !== 1'b1 || ifc.Imem_Addr !== mpc || ifc.Inst_Valid !== 1'b0) begin
                failures++;
                $display("FAIL %s req_stall: valid=%b addr=%h ivalid=%b, want 1/%h/0", tag, ifc.Imem_Req_Valid, ifc.Imem_Addr, ifc.Inst_Valid, mpc);
            end
        end
        ifc.Imem_Rsp_Valid = 1'b0;
        ifc.Imem_Req_Ready = 1'b1;
        @(negedge Clk);
        ifc.Imem_Req_Ready = 1'b0;
        repeat (rl - 1) begin
            checks++;
            if (ifc.Imem_Req_Valid !== 1'b0 || ifc.Inst_Valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait: req_valid=%b ivalid=%b, want 0/0", tag, ifc.Imem_Req_Valid, ifc.Inst_Valid);
            end
            @(negedge Clk);
        end
        ifc.Imem_Rsp_Valid = 1'b1;
        ifc.Imem_Rsp_Data  = word;
        @(negedge Clk);
        ifc.Imem_Rsp_Valid = 1'b0;
        ifc.Imem_Rsp_Data  = $urandom;
        checks++;
        if (ifc.Inst_Valid !== 1'b1 || ifc.Inst !== word || ifc.PC_Out !== mpc ||
            ifc.PC_Plus4 !== mpc + 32'd4 || ifc.Imem_Req_Valid !== 1'b0) begin
            failures++;
            $display("FAIL %s present: ivalid=%b inst=%h pc=%h p4=%h req=%b, want 1/%h/%h/%h/0", tag,
                     ifc.Inst_Valid, ifc.Inst, ifc.PC_Out, ifc.PC_Plus4, ifc.Imem_Req_Valid, word, mpc, mpc + 32'd4);
        end
        ifc.Branch           = b;
        ifc.Branch_Not_Equal = bn;
        ifc.Jump             = j;
        ifc.Zero             = z;
`ifdef INST_FETCH_JR_EN
        ifc.Jump_Reg         = jr;
        ifc.Reg_Target       = rt;
`endif
        repeat (hs) begin
            ifc.Imem_Rsp_Valid = 1'($urandom);
            ifc.Imem_Rsp_Data  = $urandom;
            @(negedge Clk);
            checks++;
            if (ifc.Inst_Valid !== 1'b1 || ifc.Inst !== word || ifc.PC_Out !== mpc || ifc.Imem_Req_Valid !== 1'b0) begin
                failures++;
                $display("FAIL %s hold: ivalid=%b inst=%h pc=%h req=%b, want 1/%h/%h/0", tag,
                         ifc.Inst_Valid, ifc.Inst, ifc.PC_Out, ifc.Imem_Req_Valid, word, mpc);
            end
        end
        ifc.Imem_Rsp_Valid = 1'b0;
        ifc.Inst_Ready     = 1'b1;
        @(negedge Clk);
        ifc.Inst_Ready = 1'b0;
        exp_next = ref_next(mpc, word, b, bn, j, z, jr, rt);
        idle_inputs();
        checks++;
        if (ifc.Inst_Valid !== 1'b0 || ifc.Imem_Req_Valid !== 1'b1 || ifc.Imem_Addr !== exp_next) begin
            failures++;
            $display("FAIL %s next_pc: ivalid=%b req=%b addr=%h, want 0/1/%h", tag,
                     ifc.Inst_Valid, ifc.Imem_Req_Valid, ifc.Imem_Addr, exp_next);
        end
        mpc = exp_next;
    endtask

    task automatic jump_to(input logic [31:0] target);
        fetch({6'd2, 26'(target >> 2)}, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0, "jump_to");
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        checks++;
        if (ifc.Imem_Req_Valid !== 1'b0 || ifc.Inst_Valid !== 1'b0 || ifc.Inst !== 32'h0 ||
            ifc.PC_Out !== 32'h0 || ifc.Imem_Addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: req=%b ivalid=%b inst=%h pc=%h addr=%h, want 0/0/0/0/0",
                     ifc.Imem_Req_Valid, ifc.Inst_Valid, ifc.Inst, ifc.PC_Out, ifc.Imem_Addr);
        end
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (ifc.Imem_Req_Valid !== 1'b1 || ifc.Imem_Addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_release: req=%b addr=%h, want 1/00000000", ifc.Imem_Req_Valid, ifc.Imem_Addr);
        end
        mpc = 32'h0;
    endtask

    task automatic test_zero_wait();
        int start;
        apply_reset();
        start = cyc;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h2008_0005, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, "zero_wait");
        end
        checks++;
        if (cyc - start != 9 || mpc !== 32'hC) begin
            failures++;
            $display("FAIL zero_wait_rate: cycles=%0d pc=%h, want 9/0000000c", cyc - start, mpc);
        end
    endtask

    task automatic test_jump();
        apply_reset();
        jump_to(32'h10);
        fetch(32'h0800_0040, 0, 1, 0, 0, 0, 1, 0, 0, 32'h0, "jump");
        checks++;
        if (ifc.Imem_Addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL jump_target: addr=%h, want 00000100", ifc.Imem_Addr);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        jump_to(32'h20);
        fetch({6'd5, 5'd1, 5'd2, 16'hFFFE}, 0, 1, 0, 0, 1, 0, 0, 0, 32'h0, "bne_taken");
        checks++;
        if (ifc.Imem_Addr !== 32'h0000_001C) begin
            failures++;
            $display("FAIL bne_taken: addr=%h, want 0000001c", ifc.Imem_Addr);
        end
        apply_reset();
        jump_to(32'h20);
        fetch({6'd5, 5'd1, 5'd2, 16'hFFFE}, 0, 1, 0, 0, 1, 0, 1, 0, 32'h0, "bne_not_taken");
        checks++;
        if (ifc.Imem_Addr !== 32'h0000_0024) begin
            failures++;
            $display("FAIL bne_not_taken: addr=%h, want 00000024", ifc.Imem_Addr);
        end
        // Jump and taken branch together: jump must win.
        fetch({6'd2, 26'h40}, 0, 1, 0, 1, 0, 1, 1, 0, 32'h0, "jump_over_branch");
    endtask

    task automatic test_stall();
        apply_reset();
        fetch(32'h8C01_0004, 4, 2, 5, 0, 0, 0, 0, 0, 32'h0, "stall");
        fetch(32'hAC01_0008, 2, 3, 1, 0, 0, 0, 0, 0, 32'h0, "stall2");
    endtask

    task automatic test_wrap();
        apply_reset();
        fetch({6'd4, 5'd0, 5'd0, 16'hFFFE}, 0, 1, 0, 1, 0, 0, 1, 0, 32'h0, "neg_branch");
        checks++;
        if (ifc.Imem_Addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL neg_branch_wrap: addr=%h, want fffffffc", ifc.Imem_Addr);
        end
        fetch(32'h0000_0020, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, "pc_wrap");
        checks++;
        if (ifc.Imem_Addr !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap: addr=%h, want 00000000", ifc.Imem_Addr);
        end
    endtask

    task automatic test_reset_in_wait();
        apply_reset();
        fetch(32'h2008_0005, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, "pre_reset");
        ifc.Imem_Req_Ready = 1'b1;
        @(negedge Clk);
        ifc.Imem_Req_Ready = 1'b0;
        Reset              = 1'b1;
        ifc.Imem_Rsp_Valid = 1'b1;
        ifc.Imem_Rsp_Data  = 32'hDEAD_BEEC;
        @(negedge Clk);
        Reset              = 1'b0;
        ifc.Imem_Rsp_Valid = 1'b0;
        @(negedge Clk);
        checks++;
        if (ifc.Inst_Valid !== 1'b0 || ifc.Imem_Req_Valid !== 1'b1 || ifc.Imem_Addr !== 32'h0 || ifc.Inst !== 32'h0) begin
            failures++;
            $display("FAIL reset_in_wait: ivalid=%b req=%b addr=%h inst=%h, want 0/1/0/0",
                     ifc.Inst_Valid, ifc.Imem_Req_Valid, ifc.Imem_Addr, ifc.Inst);
        end
        mpc = 32'h0;
        fetch(32'h2008_0005, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0, "post_reset");
    endtask

    task automatic test_jr();
        apply_reset();
        fetch(32'h0800_0040, 0, 1, 0, 0, 0, 1, 0, 1, 32'h0000_0403, "jump_reg");
`ifdef INST_FETCH_JR_EN
        checks++;
        if (ifc.Imem_Addr !== 32'h0000_0400) begin
            failures++;
            $display("FAIL jump_reg: addr=%h, want 00000400", ifc.Imem_Addr);
        end
`endif
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            fetch($urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                  ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 4) == 0, 1'($urandom),
                  ($urandom % 6) == 0, $urandom, "random");
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_zero_wait();
        test_jump();
        test_branch();
        test_stall();
        test_wrap();
        test_reset_in_wait();
        test_jr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
